// File: rtl/hex_loader.sv
// Streams readmemh-format ASCII hex text from a ready/valid byte port into memory writes.
// Define HEXLOAD_COMMENT_EN to accept "//" line comments in the text.
module hex_loader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              done,
  output logic              error
);

  localparam int ADIG  = (ADDR_W + 3) / 4;
  localparam int DDIG  = DATA_W / 4;
  localparam int ACC_W = (4 * ADIG > DATA_W) ? 4 * ADIG : DATA_W;
  localparam int MAXD  = (ADIG > DDIG) ? ADIG : DDIG;
  localparam int CNT_W = $clog2(MAXD + 1);
  localparam logic [CNT_W-1:0] ADIG_C = CNT_W'(ADIG);
  localparam logic [CNT_W-1:0] DDIG_C = CNT_W'(DDIG);

`ifdef HEXLOAD_COMMENT_EN
  typedef enum logic [2:0] {SKIP, ADDR, DATA, WRITE, DONE, ERROR, CMT1, CMT} state_t;
`else
  typedef enum logic [2:0] {SKIP, ADDR, DATA, WRITE, DONE, ERROR} state_t;
`endif

  state_t             state, nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [ADDR_W-1:0]  addr, addr_nxt;
  logic               term_nul, nul_nxt;
  logic               is_sep, is_hex, is_nul, is_at, xfer, nxt_rdy;
  logic [3:0]         nib;

  // Character classes and nibble value of the offered byte.
  always_comb begin
    is_sep = (rx_data == 8'h20) || (rx_data == 8'h09) || (rx_data == 8'h0a) || (rx_data == 8'h0d);
    is_nul = (rx_data == 8'h00);
    is_at  = (rx_data == 8'h40);
    is_hex = 1'b1;
    nib    = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39)
      nib = rx_data[3:0];
    else if ((rx_data >= 8'h61 && rx_data <= 8'h66) || (rx_data >= 8'h41 && rx_data <= 8'h46))
      nib = rx_data[3:0] + 4'd9;
    else
      is_hex = 1'b0;
  end

  assign xfer = rx_valid & rx_ready;

  always_comb begin
    nxt      = state;
    acc_nxt  = acc;
    cnt_nxt  = cnt;
    addr_nxt = addr;
    nul_nxt  = term_nul;
    case (state)
      SKIP: if (xfer) begin
        if (is_sep) nxt = SKIP;
        else if (is_at) begin
          nxt = ADDR; acc_nxt = '0; cnt_nxt = '0;
        end else if (is_hex) begin
          nxt = DATA; acc_nxt = ACC_W'(nib); cnt_nxt = CNT_W'(1);
        end else if (is_nul) nxt = DONE;
`ifdef HEXLOAD_COMMENT_EN
        else if (rx_data == 8'h2f) nxt = CMT1;
`endif
        else nxt = ERROR;
      end
      ADDR: if (xfer) begin
        if (is_hex) begin
          if (cnt == ADIG_C) nxt = ERROR;
          else begin
            acc_nxt = {acc[ACC_W-5:0], nib}; cnt_nxt = cnt + CNT_W'(1);
          end
        end else if (is_sep || is_nul) begin
          // An '@' with no digits is malformed, not address zero.
          if (cnt == '0) nxt = ERROR;
          else begin
            addr_nxt = acc[ADDR_W-1:0];
            nxt      = is_nul ? DONE : SKIP;
          end
        end else nxt = ERROR;
      end
      DATA: if (xfer) begin
        if (is_hex) begin
          if (cnt == DDIG_C) nxt = ERROR;
          else begin
            acc_nxt = {acc[ACC_W-5:0], nib}; cnt_nxt = cnt + CNT_W'(1);
          end
        end else if (is_sep || is_nul) begin
          nxt = WRITE; nul_nxt = is_nul;
        end else nxt = ERROR;
      end
      WRITE: if (mem_ready) begin
        addr_nxt = addr + ADDR_W'(1);
        nxt      = term_nul ? DONE : SKIP;
      end
`ifdef HEXLOAD_COMMENT_EN
      CMT1: if (xfer) nxt = (rx_data == 8'h2f) ? CMT : ERROR;
      CMT: if (xfer) begin
        if (rx_data == 8'h0a) nxt = SKIP;
        else if (is_nul) nxt = DONE;
      end
`endif
      default: nxt = state;
    endcase
  end

`ifdef HEXLOAD_COMMENT_EN
  assign nxt_rdy = (nxt == SKIP) || (nxt == ADDR) || (nxt == DATA) || (nxt == CMT1) || (nxt == CMT);
`else
  assign nxt_rdy = (nxt == SKIP) || (nxt == ADDR) || (nxt == DATA);
`endif

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SKIP;
      acc       <= '0;
      cnt       <= '0;
      addr      <= '0;
      term_nul  <= 1'b0;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state    <= nxt;
      acc      <= acc_nxt;
      cnt      <= cnt_nxt;
      addr     <= addr_nxt;
      term_nul <= nul_nxt;
      rx_ready <= nxt_rdy;
      mem_we   <= (nxt == WRITE);
      done     <= (nxt == DONE);
      error    <= (nxt == ERROR);
      if (state != WRITE && nxt == WRITE) begin
        mem_addr  <= addr;
        mem_wdata <= acc[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_hex_loader.sv
// Directed table-driven bench for hex_loader at default ADDR_W=16, DATA_W=64.
module tb_hex_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ready;
  logic        done;
  logic        error;

  hex_loader #(.ADDR_W(16), .DATA_W(64)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [191:0]      txt;
    logic              nul;
    logic [3:0]        stall;
    logic [1:0]        nw;
    logic [2:0][15:0]  wa;
    logic [2:0][63:0]  wd;
    logic              xdone;
    logic              xerr;
  } vec_t;

  localparam int NV = 12;
  vec_t tv [NV];

  function automatic vec_t mk(input logic [191:0] t, input logic nul, input int stall, input int nw,
                              input logic [15:0] a0, input logic [63:0] d0,
                              input logic [15:0] a1, input logic [63:0] d1,
                              input logic xd, input logic xe);
    vec_t v;
    v.txt = t; v.nul = nul; v.stall = 4'(stall); v.nw = 2'(nw);
    v.wa = '0; v.wd = '0;
    v.wa[0] = a0; v.wd[0] = d0; v.wa[1] = a1; v.wd[1] = d1;
    v.xdone = xd; v.xerr = xe;
    return v;
  endfunction

  task automatic do_reset();
    rx_valid = 1'b0; rx_data = 8'h00; mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rx_ready_after_release", rx_ready, 1);
  endtask

  task automatic run_vec(input int i);
    logic [7:0]  q[$];
    logic [7:0]  b;
    logic [15:0] cur_a;
    logic [63:0] cur_d;
    bit          started = 0;
    bit          finished = 0;
    bit          in_wr = 0;
    int          idx = 0, nwr = 0, stall_cnt = 0, idle = 0;
    vec_t        v;
    v = tv[i];
    for (int k = 23; k >= 0; k--) begin
      b = v.txt[k*8 +: 8];
      if (b != 8'h00) started = 1;
      if (started) q.push_back(b);
    end
    if (v.nul) q.push_back(8'h00);
    do_reset();
    for (int cyc = 0; cyc < 800 && !finished; cyc++) begin
      if (mem_we) begin
        chk($sformatf("v%0d rx_ready_in_write", i), rx_ready, 0);
        if (!in_wr) begin
          in_wr = 1; stall_cnt = 0; cur_a = mem_addr; cur_d = mem_wdata;
          if (nwr < int'(v.nw)) begin
            chk($sformatf("v%0d w%0d addr", i, nwr), mem_addr, v.wa[nwr]);
            chk($sformatf("v%0d w%0d data", i, nwr), mem_wdata, v.wd[nwr]);
          end else begin
            checks++; errors++;
            $display("FAIL v%0d unexpected_write: got addr %h data %h expected no write", i, mem_addr, mem_wdata);
          end
        end else begin
          chk($sformatf("v%0d stall_addr", i), mem_addr, cur_a);
          chk($sformatf("v%0d stall_data", i), mem_wdata, cur_d);
        end
        if (stall_cnt >= int'(v.stall)) begin
          mem_ready = 1'b1; in_wr = 0; nwr++;
        end else begin
          mem_ready = 1'b0; stall_cnt++;
        end
      end else mem_ready = 1'b0;
      // Every fourth cycle the byte source idles.
      if (done || error || (cyc % 4 == 3) || idx >= q.size()) rx_valid = 1'b0;
      else begin
        rx_valid = 1'b1; rx_data = q[idx];
        if (rx_ready) idx++;
      end
      if (done || error) finished = 1;
      else if (idx >= q.size() && !mem_we) begin
        idle++;
        if (idle > 12) finished = 1;
      end
      @(negedge clk);
    end
    if (!finished) begin
      checks++; errors++;
      $display("FAIL v%0d timeout: got no completion expected done/error/idle", i);
    end
    if (done || error) begin
      rx_valid = 1'b1; rx_data = 8'h31; mem_ready = 1'b1;
      repeat (4) begin
        @(negedge clk);
        chk($sformatf("v%0d term_rx_ready", i), rx_ready, 0);
        chk($sformatf("v%0d term_mem_we", i), mem_we, 0);
      end
      rx_valid = 1'b0;
    end
    chk($sformatf("v%0d nwrites", i), nwr, v.nw);
    chk($sformatf("v%0d done", i), done, v.xdone);
    chk($sformatf("v%0d error", i), error, v.xerr);
    chk($sformatf("v%0d final_rx_ready", i), rx_ready, !(v.xdone || v.xerr));
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; mem_ready = 1'b0;
    tv[0]  = mk("@10 1234 abcd", 1, 0, 2, 16'h0010, 64'h1234, 16'h0011, 64'habcd, 1, 0);
    tv[1]  = mk("5 6", 1, 3, 2, 16'h0000, 64'h5, 16'h0001, 64'h6, 1, 0);
    tv[2]  = mk("@ffff 1 2", 1, 0, 2, 16'hffff, 64'h1, 16'h0000, 64'h2, 1, 0);
    tv[3]  = mk("@20 12g4", 1, 0, 0, 16'h0, 64'h0, 16'h0, 64'h0, 0, 1);
    tv[4]  = mk("0123456789abcdef0", 1, 0, 0, 16'h0, 64'h0, 16'h0, 64'h0, 0, 1);
    tv[5]  = mk("FFFFFFFFFFFFFFFF", 1, 1, 1, 16'h0, 64'hffff_ffff_ffff_ffff, 16'h0, 64'h0, 1, 0);
`ifdef HEXLOAD_COMMENT_EN
    tv[6]  = mk("// x @5 7\n9", 1, 0, 1, 16'h0, 64'h9, 16'h0, 64'h0, 1, 0);
`else
    tv[6]  = mk("// x @5 7\n9", 1, 0, 0, 16'h0, 64'h0, 16'h0, 64'h0, 0, 1);
`endif
    tv[7]  = mk("@ 5", 1, 0, 0, 16'h0, 64'h0, 16'h0, 64'h0, 0, 1);
    tv[8]  = mk("@12345 1", 1, 0, 0, 16'h0, 64'h0, 16'h0, 64'h0, 0, 1);
    tv[9]  = mk("\t7\015\n\n 8", 1, 0, 2, 16'h0, 64'h7, 16'h1, 64'h8, 1, 0);
    tv[10] = mk("1/", 1, 0, 0, 16'h0, 64'h0, 16'h0, 64'h0, 0, 1);
    tv[11] = mk("@3 a 1f", 0, 2, 1, 16'h3, 64'ha, 16'h0, 64'h0, 0, 0);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Write strobe timing, then a reset landing in the middle of a stalled write.
    do_reset();
    rx_valid = 1'b1; rx_data = 8'h35;
    @(negedge clk);
    rx_data = 8'h20;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("seq mem_we_next_cycle", mem_we, 1);
    chk("seq mem_addr", mem_addr, 16'h0);
    chk("seq mem_wdata", mem_wdata, 64'h5);
    chk("seq rx_ready_low", rx_ready, 0);
    @(negedge clk);
    chk("seq mem_we_held", mem_we, 1);
    #1 reset = 1'b0;
    #1 chk("seq mem_we_aborted", mem_we, 0);
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("seq no_we_after_abort", mem_we, 0);
    end
    chk("seq rx_ready_after_abort", rx_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
